// File: rtl/wide_param_streamer.sv
// rtl/wide_param_streamer.sv - streams a 256-bit elaboration-time parameter as narrow words
//
// Purpose: reads back PARAM word by word over a valid/ready stream so the
// value seen after elaboration can be compared against the value overridden.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      request one transfer of PARAM (sampled in IDLE only)
//   abort      terminate the current transfer
//   out_valid  out_data holds a valid word
//   out_ready  sink accepts the word
//   out_data   current word, PARAM[out_index*WORD_W +: WORD_W]
//   out_last   final word of the transfer
//   out_index  word index within PARAM (0 = least significant word)
//   busy       transfer in progress (LOAD or SEND)
//   done       one-cycle pulse after the last word or after an abort
//   aborted    sticky abort flag, cleared by the next accepted start
module wide_param_streamer #(
    parameter logic [255:0] PARAM        = 256'h0,
    parameter int           WORD_W       = 32,
    parameter bit           MSW_FIRST    = 1'b0,
    parameter bit           SKIP_ZERO_HI = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic                             abort,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WORD_W-1:0]                out_data,
    output logic                             out_last,
    output logic [$clog2(256/WORD_W)-1:0]    out_index,
    output logic                             busy,
    output logic                             done,
    output logic                             aborted
);

    localparam int NW    = 256 / WORD_W;
    localparam int IDX_W = $clog2(NW);

    // Highest non-zero word of the parameter; 0 when the parameter is all zero.
    function automatic int highest_word(input logic [255:0] p);
        int hi;
        hi = 0;
        for (int w = 0; w < NW; w++) begin
            if (p[w*WORD_W +: WORD_W] != '0) begin
                hi = w;
            end
        end
        return hi;
    endfunction

    localparam int HI = highest_word(PARAM);
    localparam int N  = SKIP_ZERO_HI ? HI + 1 : NW;

    localparam logic [IDX_W-1:0] FIRST_IDX = MSW_FIRST ? IDX_W'(N - 1) : '0;
    localparam logic [IDX_W-1:0] FINAL_IDX = MSW_FIRST ? '0 : IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SEND = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              aborted_q, aborted_d;

    logic [WORD_W-1:0] words [NW];
    logic              at_final;
    logic              handshake;

    for (genvar w = 0; w < NW; w++) begin : g_words
        assign words[w] = PARAM[w*WORD_W +: WORD_W];
    end

    assign at_final  = (idx_q == FINAL_IDX);
    assign handshake = (state_q == S_SEND) && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            aborted_q <= aborted_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        aborted_d = aborted_q;
        unique case (state_q)
            S_IDLE: begin
                // abort in the same cycle as start wins: no words are sent
                if (start) begin
                    if (abort) begin
                        state_d   = S_DONE;
                        aborted_d = 1'b1;
                    end else begin
                        state_d   = S_LOAD;
                        aborted_d = 1'b0;
                    end
                end
            end
            S_LOAD: begin
                idx_d = FIRST_IDX;
                if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else begin
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                // the final index is never stepped past, so the counter cannot wrap
                if (handshake && !at_final) begin
                    idx_d = MSW_FIRST ? idx_q - IDX_ONE : idx_q + IDX_ONE;
                end
                if (abort) begin
                    state_d   = S_DONE;
                    aborted_d = 1'b1;
                end else if (handshake && at_final) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: decoded from registered state only, so they hold during stalls
    always_comb begin
        out_valid = 1'b0;
        out_data  = '0;
        out_last  = 1'b0;
        out_index = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_LOAD: begin
                busy = 1'b1;
            end
            S_SEND: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = words[idx_q];
                out_last  = at_final;
                out_index = idx_q;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign aborted = aborted_q;

endmodule

// File: tb/tb_wide_param_streamer.sv
// tb/tb_wide_param_streamer.sv - self-checking bench for wide_param_streamer
module tb_wide_param_streamer;

    localparam int ND = 7;

    localparam logic [255:0] PV [ND] = '{256'd4294967296, 256'd429496729600, {256{1'b1}},
                                         256'd4294967295, 256'd1, 256'd0, 256'h10000};
    localparam int WV [ND] = '{32, 32, 64, 32, 32, 16, 8};
    localparam bit MV [ND] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam bit SV [ND] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    typedef struct {
        int          dut;
        logic [63:0] data;
        int          idx;
        bit          last;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start [ND];
    logic        abort [ND];
    logic        rdy   [ND];
    logic        vld   [ND];
    logic        last  [ND];
    logic        busy  [ND];
    logic        done  [ND];
    logic        abt   [ND];
    logic [63:0] data  [ND];
    logic [4:0]  idxo  [ND];

    vec_t vec [40];
    int   nv = 0;
    vec_t sb [$];

    int total = 0;
    int bad   = 0;
    int cur   = 0;
    int vcnt  = 0;
    int dcnt  = 0;
    int acc   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int WW = WV[g];
        localparam int XW = $clog2(256 / WW);
        logic [WW-1:0] d;
        logic [XW-1:0] x;
        wide_param_streamer #(
            .PARAM       (PV[g]),
            .WORD_W      (WW),
            .MSW_FIRST   (MV[g]),
            .SKIP_ZERO_HI(SV[g])
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[g]),
            .abort     (abort[g]),
            .out_valid (vld[g]),
            .out_ready (rdy[g]),
            .out_data  (d),
            .out_last  (last[g]),
            .out_index (x),
            .busy      (busy[g]),
            .done      (done[g]),
            .aborted   (abt[g])
        );
        assign data[g] = 64'(d);
        assign idxo[g] = 5'(x);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input int d, input logic [63:0] v, input int i, input bit l);
        vec[nv] = '{d, v, i, l};
        nv++;
    endtask

    task automatic load_exp(input int k);
        for (int i = 0; i < nv; i++) begin
            if (vec[i].dut == k) sb.push_back(vec[i]);
        end
    endtask

    // Scoreboard monitor: pops one expected word per handshake on the active DUT
    initial begin
        vec_t        e;
        bit          hold;
        logic [63:0] pd;
        logic [4:0]  px;
        logic        pl;
        hold = 1'b0;
        pd   = '0;
        px   = '0;
        pl   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (vld[cur]) begin
                    vcnt++;
                    if (hold) begin
                        chk("stall_data", data[cur], pd);
                        chk("stall_index", idxo[cur], px);
                        chk("stall_last", last[cur], pl);
                    end
                    if (rdy[cur]) begin
                        hold = 1'b0;
                        chk("word_expected", sb.size() != 0, 1);
                        if (sb.size() != 0) begin
                            e = sb.pop_front();
                            chk("word_data", data[cur], e.data);
                            chk("word_index", idxo[cur], e.idx);
                            chk("word_last", last[cur], e.last);
                            acc++;
                        end
                    end else begin
                        hold = 1'b1;
                        pd   = data[cur];
                        px   = idxo[cur];
                        pl   = last[cur];
                    end
                end else begin
                    hold = 1'b0;
                end
                if (done[cur]) dcnt++;
            end
        end
    end

    // mode 0: ready held high; mode 1: ready 1,0,0 repeating; mode 2: ready high
    // with start re-pulsed mid-transfer and in the DONE cycle
    task automatic run(input int k, input int mode, input int nexp);
        int cyc;
        int stall;
        cur  = k;
        vcnt = 0;
        dcnt = 0;
        acc  = 0;
        sb.delete();
        rdy[k]   = 1'b1;
        start[k] = 1'b1;
        load_exp(k);
        tick();
        start[k] = 1'b0;
        chk("load_busy", busy[k], 1);
        chk("load_no_valid", vld[k], 0);
        chk("start_clears_aborted", abt[k], 0);
        tick();
        chk("first_valid_latency", vld[k], 1);
        cyc   = 0;
        stall = 0;
        while (!done[k] && cyc < 300) begin
            if (mode == 1) rdy[k] = (cyc % 3 == 0);
            if (mode == 2) start[k] = (cyc == 3);
            if (vld[k] && !rdy[k]) stall++;
            tick();
            cyc++;
        end
        chk("done_cycle", cyc, nexp + stall);
        chk("valid_cycles", vcnt, nexp + stall);
        chk("words_accepted", acc, nexp);
        chk("scoreboard_empty", sb.size(), 0);
        chk("done_no_valid", vld[k], 0);
        if (mode == 2) start[k] = 1'b1;
        tick();
        start[k] = 1'b0;
        rdy[k]   = 1'b1;
        chk("done_one_cycle", done[k], 0);
        tick();
        chk("stays_idle", {vld[k], busy[k]}, 0);
        chk("done_pulses", dcnt, 1);
    endtask

    initial begin
        for (int g = 0; g < ND; g++) begin
            start[g] = 1'b0;
            abort[g] = 1'b0;
            rdy[g]   = 1'b1;
        end

        for (int i = 0; i < 8; i++) add(0, (i == 1) ? 64'd1 : 64'd0, i, i == 7);
        add(1, 64'h64, 1, 1'b0);
        add(1, 64'h0, 0, 1'b1);
        for (int i = 0; i < 4; i++) add(2, 64'hFFFF_FFFF_FFFF_FFFF, i, i == 3);
        for (int i = 0; i < 8; i++) add(3, (i == 0) ? 64'hFFFF_FFFF : 64'd0, i, i == 7);
        for (int i = 0; i < 8; i++) add(4, (i == 0) ? 64'd1 : 64'd0, i, i == 7);
        add(5, 64'h0, 0, 1'b1);
        add(6, 64'h1, 2, 1'b0);
        add(6, 64'h0, 1, 1'b0);
        add(6, 64'h0, 0, 1'b1);

        #1 rst_n = 1'b0;
        #2;
        for (int g = 0; g < ND; g++) begin
            chk("rst_valid", vld[g], 0);
            chk("rst_data", data[g], 0);
            chk("rst_index", idxo[g], 0);
            chk("rst_last", last[g], 0);
            chk("rst_busy", busy[g], 0);
            chk("rst_done", done[g], 0);
            chk("rst_aborted", abt[g], 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        run(0, 0, 8);
        run(1, 0, 2);
        run(2, 1, 4);
        run(6, 0, 3);

        // start and abort together in IDLE: straight to DONE, no words
        cur  = 5;
        dcnt = 0;
        start[5] = 1'b1;
        abort[5] = 1'b1;
        tick();
        start[5] = 1'b0;
        abort[5] = 1'b0;
        chk("sa_done", done[5], 1);
        chk("sa_aborted", abt[5], 1);
        chk("sa_no_busy", busy[5], 0);
        chk("sa_no_valid", vld[5], 0);
        tick();
        chk("sa_back_idle", done[5], 0);
        run(5, 0, 1);

        // abort while word 3 is stalled
        cur  = 3;
        vcnt = 0;
        dcnt = 0;
        acc  = 0;
        sb.delete();
        load_exp(3);
        rdy[3]   = 1'b1;
        start[3] = 1'b1;
        tick();
        start[3] = 1'b0;
        tick();
        tick();
        tick();
        tick();
        rdy[3] = 1'b0;
        chk("abort_word3_index", idxo[3], 3);
        tick();
        chk("stall_holds_index", idxo[3], 3);
        abort[3] = 1'b1;
        tick();
        abort[3] = 1'b0;
        rdy[3]   = 1'b1;
        chk("abort_drops_valid", vld[3], 0);
        chk("abort_done", done[3], 1);
        chk("abort_sticky", abt[3], 1);
        chk("abort_words", acc, 3);
        tick();
        chk("abort_done_once", done[3], 0);
        chk("aborted_held", abt[3], 1);
        chk("abort_done_pulses", dcnt, 1);
        run(3, 0, 8);

        run(4, 2, 8);

        // asynchronous reset in the middle of SEND
        cur  = 4;
        dcnt = 0;
        sb.delete();
        load_exp(4);
        rdy[4]   = 1'b1;
        start[4] = 1'b1;
        tick();
        start[4] = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_reset_valid", vld[4], 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", vld[4], 0);
        chk("arst_data", data[4], 0);
        chk("arst_index", idxo[4], 0);
        chk("arst_last", last[4], 0);
        chk("arst_busy", busy[4], 0);
        chk("arst_done", done[4], 0);
        tick();
        tick();
        chk("arst_held_done", done[4], 0);
        rst_n = 1'b1;
        tick();
        chk("arst_no_done_pulse", dcnt, 0);
        chk("arst_idle", busy[4], 0);
        run(4, 0, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wide_param_streamer.md
Name: wide_param_streamer

Overview:
- Reads back a wide (256-bit) elaboration-time parameter and streams it out as narrow words over a valid/ready interface.
- This is the read side of the large-parameter override path. The bench instantiates it with overrides such as 0, 1, 4294967295, 4294967296, 429496729600 and '1, then checks the streamed words.
- The results prove that parameter values wider than 32 bits survive elaboration intact.
- Sits beside parameterised primitives in the parameter regression suite.

Parameters:
- PARAM, 256'h0, logic [255:0] value to stream; unsized integer overrides are zero-extended, '1 fills all 256 bits.
- WORD_W, 32, output word width; legal values 8, 16, 32, 64 (must divide 256).
- MSW_FIRST, 1'b0, 0 = least-significant word first, 1 = most-significant word first.
- SKIP_ZERO_HI, 1'b0, 1 = suppress leading all-zero high words (the lowest word is always sent).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request one transfer of PARAM; sampled in IDLE only
- abort  input  1  terminate the current transfer
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  sink accepts the word
- out_data  output  WORD_W  current word
- out_last  output  1  marks the final word of the transfer
- out_index  output  $clog2(256/WORD_W)  word index within PARAM (0 = LSW)
- busy  output  1  transfer in progress
- done  output  1  one-cycle pulse after the last word is accepted or an abort completes
- aborted  output  1  sticky flag; set by abort, cleared by the next start

Behaviour:
- Reset values (async on rst_n low, all outputs): out_valid=0, out_data=0, out_last=0, out_index=0, busy=0, done=0, aborted=0; FSM=IDLE.
- Derived values:
  - NW = 256/WORD_W.
  - HI = index of the highest non-zero word of PARAM, computed at elaboration; HI = 0 if PARAM = 0.
  - Word count N = HI+1 if SKIP_ZERO_HI, else NW.
- IDLE:
  - start=1 -> LOAD next cycle; aborted cleared.
  - start=1 with abort=1 in the same cycle: abort wins, go to DONE, aborted=1.
- LOAD (one cycle): initialise the counter.
  - MSW_FIRST=0: idx=0.
  - MSW_FIRST=1: idx=N-1.
  - Then go to SEND.
- SEND:
  - out_valid=1, out_data=PARAM[idx*WORD_W +: WORD_W], out_index=idx.
  - out_last=1 when idx is the final index: N-1 if LSW-first, 0 if MSW-first.
  - out_data, out_index and out_last must stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: advance idx (±1 by order); if out_last, go to DONE.
  - A word accepted with no stall yields back-to-back words, one per cycle.
- Latency: start (IDLE) -> first out_valid exactly 2 cycles later.
- busy = 1 in LOAD and SEND.
- DONE (one cycle): done=1, out_valid=0, then IDLE.
- abort in LOAD or SEND:
  - Next cycle go to DONE, out_valid=0, aborted=1.
  - A word handshaken in the same cycle as abort counts as delivered.
- start while busy or in DONE is ignored; there is no queuing.
- out_ready while out_valid=0 is ignored.
- Index counter width is $clog2(NW); it never wraps past N-1 or below 0.
- Reset mid-transfer returns to IDLE immediately; no done pulse.
- Edge cases:
  - PARAM=0 with SKIP_ZERO_HI=1: a single word, value 0, out_last=1.
  - WORD_W=256/NW=1 is not supported.

Test Plan:
- PARAM=4294967296, WORD_W=32, LSW-first, out_ready=1 -> 8 words 0,1,0,0,0,0,0,0 on consecutive cycles; out_last on index 7; done 1 cycle after the last word; first valid 2 cycles after start.
- PARAM=429496729600, SKIP_ZERO_HI=1, MSW_FIRST=1 -> 2 words: 0x00000064 (idx 1), then 0x00000000 (idx 0, last).
- PARAM='1, WORD_W=64, out_ready toggling 1,0,0,1... -> 4 words of 0xFFFF_FFFF_FFFF_FFFF; data and index held during stalls; total valid cycles = 4 + stall count.
- PARAM=4294967295, abort asserted while word 3 is presented with out_ready=0 -> out_valid drops next cycle, done pulses once, aborted=1; the next start clears aborted and resends from word 0.
- PARAM=1, start asserted again mid-transfer and in the DONE cycle -> ignored; exactly 8 words and 1 done pulse.
- rst_n low mid-SEND (asynchronous, between clock edges) -> all outputs 0 immediately, no done pulse; the transfer restarts cleanly on the next start.
